// File: rtl/mmcm_drp_ctrl.sv
// MMCME2_ADV reconfiguration sequencer: holds the MMCM in reset, applies a captured
// table of masked read-modify-write DRP updates, releases reset and waits for LOCKED.
module mmcm_drp_ctrl #(
    parameter int NREG         = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 REQ,
    input  logic [7*NREG-1:0]    CFG_ADDR,
    input  logic [16*NREG-1:0]   CFG_MASK,
    input  logic [16*NREG-1:0]   CFG_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [6:0]           DADDR,
    output logic [15:0]          DI,
    output logic                 DEN,
    output logic                 DWE,
    input  logic [15:0]          DO,
    input  logic                 DRDY,
    output logic                 MMCM_RST,
    input  logic                 LOCKED
);

    localparam int              IDXW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREG - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [15:0]     LOCK_TO  = 16'(LOCK_TIMEOUT);
    localparam logic [7:0]      DRDY_TO  = 8'(DRDY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_REL, S_LOCK_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [15:0]     lcnt_q, lcnt_d;
    logic [6:0]      addr_q [NREG];
    logic [15:0]     mask_q [NREG];
    logic [15:0]     data_q [NREG];
    logic [6:0]      daddr_q, daddr_d;
    logic [15:0]     di_q, di_d;
    logic            den_q, den_d, dwe_q, dwe_d;
    logic            rst_q, rst_d, busy_q, busy_d;
    logic            done_q, done_d, err_q, err_d;
    logic            cap_s;

    // Mask bit 1 keeps the bit read back from the MMCM, 0 takes the new data bit.
    function automatic logic [15:0] rmw_merge(input logic [15:0] old_v,
                                              input logic [15:0] keep_v,
                                              input logic [15:0] new_v);
        return (old_v & keep_v) | (new_v & ~keep_v);
    endfunction

    // Sequencer next state; DI doubles as the merged-word register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        lcnt_d  = lcnt_q;
        di_d    = di_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cap_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    cap_s   = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_RST_ON;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST_ON: begin
                idx_d   = '0;
                state_d = S_RD;
            end
            S_RD: begin
                wcnt_d  = 8'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (DRDY) begin
                    di_d    = rmw_merge(DO, mask_q[idx_q], data_q[idx_q]);
                    state_d = S_WR;
                end else if (wcnt_q == DRDY_TO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            S_WR: begin
                wcnt_d  = 8'd0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (DRDY) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_REL;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_RD;
                    end
                end else if (wcnt_q == DRDY_TO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            S_REL: begin
                lcnt_d  = 16'd0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                // The first four cycles mask a LOCKED left over from before the reset pulse.
                if (LOCKED && (lcnt_q >= 16'd4)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (lcnt_q == LOCK_TO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lcnt_d  = lcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output strobes are decoded from the next state so every pin comes from a flop.
    always_comb begin
        den_d  = (state_d == S_RD) || (state_d == S_WR);
        dwe_d  = (state_d == S_WR);
        busy_d = (state_d != S_IDLE);
        rst_d  = (state_d != S_IDLE) && (state_d != S_LOCK_WAIT);
        if (den_d) begin
            daddr_d = addr_q[idx_d];
        end else begin
            daddr_d = daddr_q;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= 8'd0;
            lcnt_q  <= 16'd0;
            daddr_q <= 7'd0;
            di_q    <= 16'd0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            lcnt_q  <= lcnt_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Table snapshot taken only when a request is accepted.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int i = 0; i < NREG; i++) begin
                addr_q[i] <= 7'd0;
                mask_q[i] <= 16'd0;
                data_q[i] <= 16'd0;
            end
        end else if (cap_s) begin
            for (int i = 0; i < NREG; i++) begin
                addr_q[i] <= CFG_ADDR[7*i +: 7];
                mask_q[i] <= CFG_MASK[16*i +: 16];
                data_q[i] <= CFG_DATA[16*i +: 16];
            end
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign DADDR    = daddr_q;
    assign DI       = di_q;
    assign DEN      = den_q;
    assign DWE      = dwe_q;
    assign MMCM_RST = rst_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl: a DRP register model answers reads/writes, and
// expected read addresses / written words are queued at request time and popped on DEN.
module tb_mmcm_drp_ctrl;

    localparam int NREG    = 2;
    localparam int LOCK_TO = 1000;
    localparam int DRDY_TO = 255;

    logic                 CLK;
    logic                 RST_X;
    logic                 REQ;
    logic [7*NREG-1:0]    CFG_ADDR;
    logic [16*NREG-1:0]   CFG_MASK;
    logic [16*NREG-1:0]   CFG_DATA;
    logic                 BUSY, DONE, ERR;
    logic [6:0]           DADDR;
    logic [15:0]          DI;
    logic                 DEN, DWE;
    logic [15:0]          DO;
    logic                 DRDY;
    logic                 MMCM_RST;
    logic                 LOCKED;

    mmcm_drp_ctrl #(.NREG(NREG), .LOCK_TIMEOUT(LOCK_TO), .DRDY_TIMEOUT(DRDY_TO)) dut (
        .CLK(CLK), .RST_X(RST_X), .REQ(REQ),
        .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .DADDR(DADDR), .DI(DI), .DEN(DEN), .DWE(DWE),
        .DO(DO), .DRDY(DRDY), .MMCM_RST(MMCM_RST), .LOCKED(LOCKED)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr [$];
    logic [6:0]  exp_rd [$];
    logic [15:0] mem [128];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          pend, pend_rd, den_prev;
    logic [6:0]  pend_addr;
    int          drop_rd, rd_cnt, wr_cnt, den_cnt, rst_hi, done_cnt;
    logic [6:0]  ca [NREG];
    logic [15:0] cm [NREG];
    logic [15:0] cd [NREG];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] k,
                                          input logic [15:0] d);
        return (o & k) | (d & ~k);
    endfunction

    // One clock: advance the DRP model, score DEN transactions, tally pins.
    task automatic cycle();
        wr_t e;
        @(negedge CLK);
        DRDY = pend;
        DO   = (pend && pend_rd) ? mem[pend_addr] : 16'h0BAD;
        pend = 1'b0;
        if (DEN) begin
            den_cnt++;
            chk("den_gap", 32'(den_prev), 32'd0);
            if (DWE) begin
                wr_cnt++;
                n_cmp++;
                assert (exp_wr.size() != 0) else begin
                    n_err++;
                    $error("FAIL wr_unexpected: observed write %0h to %0h expected none", DI, DADDR);
                end
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(DADDR), 32'(e.addr));
                    chk("wr_data", 32'(DI), 32'(e.data));
                end
                mem[DADDR] = DI;
                pend = 1'b1; pend_rd = 1'b0; pend_addr = DADDR;
            end else begin
                rd_cnt++;
                n_cmp++;
                assert (exp_rd.size() != 0) else begin
                    n_err++;
                    $error("FAIL rd_unexpected: observed read of %0h expected none", DADDR);
                end
                if (exp_rd.size() != 0) chk("rd_addr", 32'(DADDR), 32'(exp_rd.pop_front()));
                if (rd_cnt - 1 != drop_rd) begin
                    pend = 1'b1; pend_rd = 1'b1; pend_addr = DADDR;
                end
            end
        end
        if (DWE) chk("dwe_needs_den", 32'(DEN), 32'd1);
        if (DONE || ERR) chk("done_err_excl", 32'(DONE & ERR), 32'd0);
        if (MMCM_RST) rst_hi++;
        if (DONE) done_cnt++;
        den_prev = DEN;
    endtask

    task automatic set_cfg(input logic [6:0] a0, input logic [15:0] m0, input logic [15:0] d0,
                           input logic [6:0] a1, input logic [15:0] m1, input logic [15:0] d1);
        ca[0] = a0; cm[0] = m0; cd[0] = d0;
        ca[1] = a1; cm[1] = m1; cd[1] = d1;
        CFG_ADDR = {a1, a0};
        CFG_MASK = {m1, m0};
        CFG_DATA = {d1, d0};
    endtask

    // Drive REQ for one edge; returns at the RST_ON cycle with expectations queued.
    task automatic run_req();
        wr_t e;
        rd_cnt = 0; wr_cnt = 0; den_cnt = 0; rst_hi = 0; done_cnt = 0;
        for (int i = 0; i < NREG; i++) begin
            exp_rd.push_back(ca[i]);
            e.addr = ca[i];
            e.data = merge(mem[ca[i]], cm[i], cd[i]);
            exp_wr.push_back(e);
        end
        REQ = 1'b1;
        cycle();
        REQ = 1'b0;
    endtask

    task automatic wait_lock(input int max, output int n);
        n = 0;
        while (!(BUSY && !MMCM_RST) && n < max) begin
            cycle();
            n++;
        end
        chk("lock_wait_entry", 32'(BUSY & ~MMCM_RST), 32'd1);
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!DONE && n < max) begin
            cycle();
            n++;
        end
        chk("done_seen", 32'(DONE), 32'd1);
    endtask

    initial begin
        int n;
        RST_X = 1'b0; REQ = 1'b0; LOCKED = 1'b0; DRDY = 1'b0; DO = 16'h0000;
        CFG_ADDR = '0; CFG_MASK = '0; CFG_DATA = '0;
        pend = 1'b0; pend_rd = 1'b0; pend_addr = 7'd0; den_prev = 1'b0; drop_rd = -1;
        rd_cnt = 0; wr_cnt = 0; den_cnt = 0; rst_hi = 0; done_cnt = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
        mem[7'h10] = 16'h1357;

        // Reset state
        repeat (3) cycle();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_den", 32'(DEN), 32'd0);
        chk("rst_mmcm", 32'(MMCM_RST), 32'd0);
        chk("rst_daddr", 32'(DADDR), 32'd0);
        chk("rst_di", 32'(DI), 32'd0);
        RST_X = 1'b1;
        cycle();

        // Nominal: two RMW entries, lock raised 10 cycles after REL
        set_cfg(7'h08, 16'hFF00, 16'h1234, 7'h09, 16'h0F0F, 16'hA5A5);
        run_req();
        chk("rst_on_busy", 32'(BUSY), 32'd1);
        chk("rst_on_mmcm", 32'(MMCM_RST), 32'd1);
        wait_lock(50, n);
        chk("lock_entry_latency", 32'(n + 1), 32'd11);
        chk("mmcm_rst_cycles", 32'(rst_hi), 32'd10);
        chk("den_pulses", 32'(den_cnt), 32'd4);
        chk("wr_q_empty", 32'(exp_wr.size()), 32'd0);
        chk("mem08", 32'(mem[7'h08]), 32'h0000FF34);
        chk("mem09", 32'(mem[7'h09]), 32'h0000AFAF);
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk("lw_busy", 32'(BUSY), 32'd1);
        end
        LOCKED = 1'b1;
        cycle();
        chk("nom_done", 32'(DONE), 32'd1);
        chk("nom_err", 32'(ERR), 32'd0);
        chk("nom_idle", 32'(BUSY), 32'd0);
        cycle();
        chk("done_pulse", 32'(DONE), 32'd0);
        repeat (3) cycle();
        chk("daddr_hold", 32'(DADDR), 32'h09);
        chk("di_hold", 32'(DI), 32'h0000AFAF);

        // Immediate lock: DONE only after the four masked LOCK_WAIT cycles
        set_cfg(7'h10, 16'h00FF, 16'h5A00, 7'h08, 16'hF0F0, 16'h0000);
        run_req();
        wait_lock(50, n);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("early_done", 32'(DONE), 32'd0);
        end
        cycle();
        chk("imm_done", 32'(DONE), 32'd1);
        chk("imm_done_cnt", 32'(done_cnt), 32'd1);
        chk("mem10", 32'(mem[7'h10]), 32'h00005A57);
        chk("mem08b", 32'(mem[7'h08]), 32'h0000F030);

        // DRDY withheld on the second read
        set_cfg(7'h20, 16'h0000, 16'h1111, 7'h21, 16'h0000, 16'h2222);
        drop_rd = 1;
        run_req();
        n = 0;
        while (rd_cnt < 2 && n < 40) begin
            cycle();
            n++;
        end
        chk("second_read", 32'(rd_cnt), 32'd2);
        repeat (DRDY_TO + 1) cycle();
        chk("to_err_early", 32'(ERR), 32'd0);
        chk("to_busy_early", 32'(BUSY), 32'd1);
        cycle();
        chk("to_err", 32'(ERR), 32'd1);
        chk("to_busy", 32'(BUSY), 32'd0);
        chk("to_mmcm", 32'(MMCM_RST), 32'd0);
        repeat (5) cycle();
        chk("err_sticky", 32'(ERR), 32'd1);
        chk("to_no_done", 32'(done_cnt), 32'd0);
        chk("to_wr_left", 32'(exp_wr.size()), 32'd1);
        exp_wr.delete();
        exp_rd.delete();
        drop_rd = -1;

        // Lock never arrives
        LOCKED = 1'b0;
        set_cfg(7'h22, 16'hFFFF, 16'h0000, 7'h23, 16'h0000, 16'h3333);
        run_req();
        chk("err_cleared", 32'(ERR), 32'd0);
        wait_lock(50, n);
        repeat (LOCK_TO) cycle();
        chk("lk_err_early", 32'(ERR), 32'd0);
        chk("lk_busy_early", 32'(BUSY), 32'd1);
        cycle();
        chk("lk_err", 32'(ERR), 32'd1);
        chk("lk_busy", 32'(BUSY), 32'd0);
        chk("lk_no_done", 32'(done_cnt), 32'd0);
        LOCKED = 1'b1;
        run_req();
        chk("lk_err_cleared", 32'(ERR), 32'd0);
        wait_done(60);

        // REQ and CFG disturbed mid-sequence
        set_cfg(7'h30, 16'h0000, 16'hC0DE, 7'h31, 16'h00F0, 16'h2222);
        run_req();
        repeat (3) cycle();
        REQ = 1'b1;
        CFG_ADDR = {7'h41, 7'h40};
        CFG_MASK = '0;
        CFG_DATA = {16'h9999, 16'h8888};
        repeat (4) cycle();
        REQ = 1'b0;
        wait_done(60);
        chk("mid_done_cnt", 32'(done_cnt), 32'd1);
        chk("mid_reads", 32'(rd_cnt), 32'd2);
        chk("mid_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("mem31", 32'(mem[7'h31]), 32'h000022F2);
        chk("mem40", 32'(mem[7'h40]), 32'h0000FFFF);
        repeat (3) cycle();
        chk("mid_no_restart", 32'(BUSY), 32'd0);

        // Asynchronous reset in WR_WAIT
        LOCKED = 1'b0;
        set_cfg(7'h50, 16'hFF00, 16'h00AB, 7'h51, 16'h0000, 16'h7777);
        run_req();
        n = 0;
        while (wr_cnt < 1 && n < 40) begin
            cycle();
            n++;
        end
        cycle();
        chk("pre_rst_mmcm", 32'(MMCM_RST), 32'd1);
        #2;
        RST_X = 1'b0;
        DRDY  = 1'b0;
        #1;
        chk("arst_mmcm", 32'(MMCM_RST), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_den", 32'(DEN), 32'd0);
        exp_wr.delete();
        exp_rd.delete();
        pend = 1'b0;
        repeat (2) cycle();
        RST_X = 1'b1;
        cycle();
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_daddr", 32'(DADDR), 32'd0);
        LOCKED = 1'b1;
        run_req();
        wait_done(60);
        chk("rerun_reads", 32'(rd_cnt), 32'd2);
        chk("rerun_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("mem50", 32'(mem[7'h50]), 32'h0000FFAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
